// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the 480x360 serial display path.
package fb_pkg;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 3;
    localparam int H_VISIBLE = 480;
    localparam int V_VISIBLE = 360;
    localparam int FB_WORDS  = H_VISIBLE * V_VISIBLE;

    // Owner of the single RAM port for the next cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that buffers serial-side pixel writes until the
// display leaves the RAM port free. Full/empty come from the level counter.
module fb_wr_fifo #(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [ADDR_W-1:0]             i_push_addr,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_pop,
    output logic [ADDR_W-1:0]             o_head_addr,
    output logic [DATA_W-1:0]             o_head_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_full,
    output logic                          o_empty
);
    import fb_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addrMem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_dataMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [LVL_W-1:0]  r_level;

    // Storage is written on every accepted push; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addrMem[r_wrPtr] <= i_push_addr;
            r_dataMem[r_wrPtr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head_addr = r_addrMem[r_rdPtr];
    assign o_head_data = r_dataMem[r_rdPtr];
    assign o_level     = r_level;
    assign o_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign o_empty     = (r_level == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win the RAM port,
// buffered serial writes drain into the cycles the display leaves free.
module vga_fb_arbiter #(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk_vga,
    input  logic                          i_rst,
    input  logic                          i_disp_req,
    input  logic [ADDR_W-1:0]             i_disp_addr,
    output logic [DATA_W-1:0]             o_disp_data,
    output logic                          o_disp_valid,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_mem_we,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    import fb_pkg::*;

    logic [ADDR_W-1:0]          w_headAddr;
    logic [DATA_W-1:0]          w_headData;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_wrReady;
    logic                       w_push;
    logic                       w_pop;
    grant_t                     w_grant;

    logic [ADDR_W-1:0]          r_memAddr;
    logic                       r_memWe;
    logic [DATA_W-1:0]          r_memWdata;
    logic [1:0]                 r_tag;

    // Readiness looks only at the registered level, so a same-cycle pop
    // never frees a slot for a push while full.
    assign w_wrReady = !w_full && !i_rst;
    assign w_push    = i_wr_valid && w_wrReady;
    assign w_pop     = (w_grant == GNT_WRITE);

    fb_wr_fifo #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wrFifo (
        .i_clk       (i_clk_vga),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_addr (i_wr_addr),
        .i_push_data (i_wr_data),
        .i_pop       (w_pop),
        .o_head_addr (w_headAddr),
        .o_head_data (w_headData),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Fixed priority: display first, then a pending write, else idle.
    always_comb begin
        w_grant = GNT_IDLE;
        if (i_disp_req) begin
            w_grant = GNT_DISP;
        end else if (!w_empty) begin
            w_grant = GNT_WRITE;
        end
    end

    // Grant register drives the RAM port; idle keeps the last address.
    always_ff @(posedge i_clk_vga) begin
        if (i_rst) begin
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end else begin
            case (w_grant)
                GNT_DISP: begin
                    r_memAddr <= i_disp_addr;
                    r_memWe   <= 1'b0;
                end
                GNT_WRITE: begin
                    r_memAddr  <= w_headAddr;
                    r_memWdata <= w_headData;
                    r_memWe    <= 1'b1;
                end
                default: begin
                    r_memWe <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage tag lines up with the address register plus RAM latency.
    always_ff @(posedge i_clk_vga) begin
        if (i_rst) begin
            r_tag <= 2'b00;
        end else begin
            r_tag <= {r_tag[0], (w_grant == GNT_DISP)};
        end
    end

    assign o_disp_data  = i_mem_rdata;
    assign o_disp_valid = r_tag[1];
    assign o_wr_ready   = w_wrReady;
    assign o_mem_addr   = r_memAddr;
    assign o_mem_we     = r_memWe;
    assign o_mem_wdata  = r_memWdata;
    assign o_fifo_level = w_level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter with a behavioural synchronous RAM.
module tb_vga_fb_arbiter;

    localparam int AW = 18;
    localparam int DW = 3;
    localparam int WORDS = 480 * 360;

    logic          clk;
    logic          rst;
    logic          dispReq;
    logic [AW-1:0] dispAddr;
    logic [DW-1:0] dispData;
    logic          dispValid;
    logic          wrValid;
    logic          wrReady;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic [2:0]    fifoLevel;

    logic [DW-1:0] ram [WORDS];

    int testsRun;
    int testsFailed;

    vga_fb_arbiter dut (
        .i_clk_vga    (clk),
        .i_rst        (rst),
        .i_disp_req   (dispReq),
        .i_disp_addr  (dispAddr),
        .o_disp_data  (dispData),
        .o_disp_valid (dispValid),
        .i_wr_valid   (wrValid),
        .o_wr_ready   (wrReady),
        .i_wr_addr    (wrAddr),
        .i_wr_data    (wrData),
        .o_mem_addr   (memAddr),
        .o_mem_we     (memWe),
        .o_mem_wdata  (memWdata),
        .i_mem_rdata  (memRdata),
        .o_fifo_level (fifoLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM: data for the registered address appears
    // one cycle later.
    always @(posedge clk) begin
        memRdata <= ram[memAddr];
        if (memWe) ram[memAddr] = memWdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input int addr, input logic wv,
                                 input int wa, input logic [DW-1:0] wd);
        dispReq  = req;
        dispAddr = AW'(addr);
        wrValid  = wv;
        wrAddr   = AW'(wa);
        wrData   = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            next;
    int            validCount;
    int            firstValid;
    int            dataErr;
    int            weCount;
    logic [7:0]    weMask;
    logic [7:0]    readyLog;
    logic [AW-1:0] addrLog [8];
    logic [DW-1:0] dataLog [8];
    logic [2:0]    levelLog [8];
    logic [DW-1:0] expData;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < WORDS; i++) ram[i] = DW'(i);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, 3'd0);

        // Reset state
        tick();
        tick();
        checkOutput("reset_mem_we", 32'(memWe), 0);
        checkOutput("reset_mem_addr", 32'(memAddr), 0);
        checkOutput("reset_mem_wdata", 32'(memWdata), 0);
        checkOutput("reset_disp_valid", 32'(dispValid), 0);
        checkOutput("reset_wr_ready", 32'(wrReady), 0);
        checkOutput("reset_fifo_level", 32'(fifoLevel), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_wr_ready", 32'(wrReady), 1);

        // Single write on an idle bus to the last frame address
        applyStimulus(1'b0, 0, 1'b1, 172799, 3'b101);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 3'd0);
        checkOutput("single_level_k1", 32'(fifoLevel), 1);
        checkOutput("single_we_k1", 32'(memWe), 0);
        tick();
        checkOutput("single_we_k2", 32'(memWe), 1);
        checkOutput("single_addr_k2", 32'(memAddr), 172799);
        checkOutput("single_wdata_k2", 32'(memWdata), 5);
        checkOutput("single_level_k2", 32'(fifoLevel), 0);
        tick();
        checkOutput("single_we_k3", 32'(memWe), 0);
        checkOutput("single_ram", 32'(ram[172799]), 5);

        // Display burst of one visible line
        validCount = 0; firstValid = -1; dataErr = 0; weCount = 0;
        for (int c = 0; c < 483; c++) begin
            applyStimulus(c < 480, c, 1'b0, 0, 3'd0);
            tick();
            if (dispValid) begin
                validCount++;
                if (firstValid < 0) firstValid = c;
                expData = DW'(c - 1);
                if (dispData !== expData) dataErr++;
            end
            if (memWe) weCount++;
        end
        checkOutput("burst_valid_count", 32'(validCount), 480);
        checkOutput("burst_first_valid", 32'(firstValid), 1);
        checkOutput("burst_data_errors", 32'(dataErr), 0);
        checkOutput("burst_mem_we", 32'(weCount), 0);

        // Six writes offered while the display holds the port
        next = 0; weCount = 0; readyLog = '0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 5, 1'b1, 1000 + next, DW'(next + 1));
            readyLog[c] = wrReady;
            tick();
            if (readyLog[c]) next++;
            if (memWe) weCount++;
        end
        checkOutput("line_ready_log", 32'(readyLog[5:0]), 32'h0F);
        checkOutput("line_accepted", 32'(next), 4);
        checkOutput("line_level_full", 32'(fifoLevel), 4);
        checkOutput("line_no_we", 32'(weCount), 0);

        // Display drops: FIFO drains in order, refills behind the pops
        weMask = '0; readyLog = '0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 5, next < 6, 1000 + next, DW'(next + 1));
            readyLog[c] = wrReady;
            tick();
            if (wrValid && readyLog[c]) next++;
            weMask[c]   = memWe;
            addrLog[c]  = memAddr;
            dataLog[c]  = memWdata;
            levelLog[c] = fifoLevel;
        end
        checkOutput("drain_ready_full", 32'(readyLog[0]), 0);
        checkOutput("drain_ready_after_pop", 32'(readyLog[1]), 1);
        checkOutput("drain_level_c0", 32'(levelLog[0]), 3);
        checkOutput("drain_level_c1", 32'(levelLog[1]), 3);
        checkOutput("drain_level_c3", 32'(levelLog[3]), 2);
        checkOutput("drain_level_c5", 32'(levelLog[5]), 0);
        checkOutput("drain_all_accepted", 32'(next), 6);
        checkOutput("drain_we_mask", 32'(weMask), 32'h3F);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("drain_addr_%0d", c), 32'(addrLog[c]), 32'(1000 + c));
            checkOutput($sformatf("drain_data_%0d", c), 32'(dataLog[c]), 32'(c + 1));
        end

        // Interleave: queue two writes, then disp_req 1,0,1,0,0
        applyStimulus(1'b1, 10, 1'b1, 2000, 3'd6);
        tick();
        applyStimulus(1'b1, 10, 1'b1, 2001, 3'd7);
        tick();
        checkOutput("ilv_queued", 32'(fifoLevel), 2);
        applyStimulus(1'b1, 20, 1'b0, 0, 3'd0);
        tick();
        checkOutput("ilv_e0_we", 32'(memWe), 0);
        checkOutput("ilv_e0_addr", 32'(memAddr), 20);
        applyStimulus(1'b0, 0, 1'b0, 0, 3'd0);
        tick();
        checkOutput("ilv_e1_we", 32'(memWe), 1);
        checkOutput("ilv_e1_addr", 32'(memAddr), 2000);
        checkOutput("ilv_e1_data", 32'(memWdata), 6);
        checkOutput("ilv_e1_valid", 32'(dispValid), 1);
        checkOutput("ilv_e1_pixel", 32'(dispData), 4);
        applyStimulus(1'b1, 21, 1'b0, 0, 3'd0);
        tick();
        checkOutput("ilv_e2_we", 32'(memWe), 0);
        checkOutput("ilv_e2_addr", 32'(memAddr), 21);
        checkOutput("ilv_e2_valid", 32'(dispValid), 0);
        applyStimulus(1'b0, 0, 1'b0, 0, 3'd0);
        tick();
        checkOutput("ilv_e3_we", 32'(memWe), 1);
        checkOutput("ilv_e3_addr", 32'(memAddr), 2001);
        checkOutput("ilv_e3_data", 32'(memWdata), 7);
        checkOutput("ilv_e3_valid", 32'(dispValid), 1);
        checkOutput("ilv_e3_pixel", 32'(dispData), 5);
        tick();
        checkOutput("ilv_e4_we", 32'(memWe), 0);
        checkOutput("ilv_e4_addr_held", 32'(memAddr), 2001);
        checkOutput("ilv_e4_level", 32'(fifoLevel), 0);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 7, 1'b1, 3000 + i, DW'(i + 1));
            tick();
        end
        checkOutput("rmd_level3", 32'(fifoLevel), 3);
        applyStimulus(1'b0, 0, 1'b0, 0, 3'd0);
        tick();
        checkOutput("rmd_first_we", 32'(memWe), 1);
        checkOutput("rmd_first_addr", 32'(memAddr), 3000);
        rst = 1'b1;
        #1;
        checkOutput("rmd_ready_in_reset", 32'(wrReady), 0);
        tick();
        checkOutput("rmd_we_cleared", 32'(memWe), 0);
        checkOutput("rmd_addr_cleared", 32'(memAddr), 0);
        checkOutput("rmd_wdata_cleared", 32'(memWdata), 0);
        checkOutput("rmd_level_cleared", 32'(fifoLevel), 0);
        rst = 1'b0;
        #1;
        checkOutput("rmd_ready_after", 32'(wrReady), 1);
        weCount = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (memWe) weCount++;
        end
        checkOutput("rmd_no_more_we", 32'(weCount), 0);
        checkOutput("rmd_ram_first", 32'(ram[3000]), 1);
        checkOutput("rmd_ram_discarded", 32'(ram[3001]), 1);
        checkOutput("rmd_ram_discarded2", 32'(ram[3002]), 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter for the 480x360 serial display. It shares one synchronous single-port pixel RAM between two requesters: the VGA pixel-fetch path, which has absolute priority, and the serial-side pixel writer, which gets only cycles the display leaves free. A 4-entry write FIFO absorbs serial writes issued during visible lines, and writes drain during idle cycles and blanking.

## Interface
Parameters:
- ADDR_W, 18, frame-buffer address width (480*360 = 172800 words)
- DATA_W, 3, pixel width (1 bit each R, G, B)
- FIFO_DEPTH, 4, write-buffer entries; power of two, at least 2

Ports:
- clk_vga  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display needs the pixel at disp_addr
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  read pixel; valid only when disp_valid is high
- disp_valid  out  1  disp_data carries the pixel for the request issued 2 cycles earlier
- wr_valid  in  1  serial writer offers a pixel
- wr_ready  out  1  FIFO accepts the offer this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after mem_addr
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push: a write is accepted when wr_valid and wr_ready are both high at a clk_vga edge. wr_ready = !full && !rst. It depends only on the registered level, so a pop in the same cycle never makes room for a push while the FIFO is full.
- Each cycle, the arbiter picks one grant:
  - DISP if disp_req is high.
  - WRITE if disp_req is low and the FIFO is not empty. The head is popped.
  - IDLE otherwise.
- Grant register:
  - DISP loads mem_addr = disp_addr and mem_we = 0.
  - WRITE loads mem_addr/mem_wdata from the FIFO head and mem_we = 1.
  - IDLE holds mem_addr and sets mem_we = 0.
- Read tag: a 2-stage shift register carries "DISP granted". disp_valid is the stage-2 output, and disp_data = mem_rdata passed straight through.
- Occupancy: simultaneous push and pop leaves the level unchanged. Push on full and pop on empty cannot occur by construction.
- Starvation: writes may wait indefinitely while disp_req stays high. The display side guarantees blanking gaps; no timeout.
- Read-after-write ordering is not enforced. A display read of an address with a pending FIFO write returns the old pixel.
- Reset, in any state, including mid-drain:
  - FIFO is emptied; pending writes are discarded.
  - Tag pipeline is cleared.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - disp_valid = 0, wr_ready = 0, fifo_level = 0.

## Timing
- Display read latency is exactly 2 cycles:
  - disp_req sampled at edge k.
  - mem_addr valid in cycle k+1.
  - mem_rdata and disp_valid in cycle k+2.
- Back-to-back disp_req gives one pixel per clock.
- Write latency:
  - Accept at edge k, with disp_req low and FIFO empty: mem_we is high in cycle k+2.
  - Entry appears at the head in cycle k+1.
  - The arbiter decides at edge k+1, so no bypass path exists.
- Write FIFO pointers wrap modulo FIFO_DEPTH; full/empty come from the level counter, not pointer comparison.
- All outputs are registered, except these combinational ones:
  - disp_data (from mem_rdata)
  - wr_ready (from the level register and rst)

## Structure
- Shared package fb_pkg: ADDR_W, DATA_W, the frame constants H_VISIBLE = 480 and V_VISIBLE = 360, and the enum grant_t {GNT_IDLE, GNT_DISP, GNT_WRITE}.
- One sub-module: fb_wr_fifo (synchronous FIFO with push, pop, level, full, empty; parameter FIFO_DEPTH).
- Arbiter, grant register and tag pipeline live in the top module.

## Test plan
- Reset mid-drain: fill 3 entries, hold disp_req low, assert rst for 1 cycle after the first write issues -> remaining writes never reach mem_we; fifo_level = 0; wr_ready = 0 during reset and 1 after.
- Display burst: disp_req high for 480 cycles with disp_addr 0..479 and RAM preloaded data = addr[2:0] -> disp_valid high for exactly 480 cycles starting 2 cycles after the first request; disp_data sequence matches; mem_we never high.
- Writes during visible line: offer 6 writes while disp_req is held high -> 4 accepted and wr_ready low after the 4th; after disp_req drops, 4 writes on mem_we in FIFO order on consecutive cycles; then the remaining 2 are accepted and written.
- Interleave: disp_req pattern 1,0,1,0 with 2 queued writes -> writes appear on mem_* only in cycles following disp_req = 0 grants; reads return on the correct cycles.
- Full with simultaneous pop: FIFO full, disp_req low, wr_valid high -> no push the cycle the pop occurs; the push is accepted the next cycle; fifo_level goes 4, 3, 3.
- Single write, idle bus: one accepted write to address 172799 with data 3'b101 -> mem_we = 1, mem_addr = 172799, mem_wdata = 3'b101 exactly 2 cycles after acceptance.
